// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences the title screen, serve, rally, pause, point
// and game-over phases, and keeps per-player scores.
module pong_match_ctrl #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                       clk_0,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       start_btn,
  input  logic                       pause_btn,
  input  logic                       point_valid,
  input  logic [PW-1:0]              point_player,
  output logic [2:0]                 state,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [PW-1:0]              serve_player,
  output logic [PW-1:0]              winner,
  output logic                       ball_enable,
  output logic                       sq_shown,
  output logic                       game_startup,
  output logic                       game_over
);

  // A frame count of 0 is treated as 1 so the phase still lasts one tick.
  localparam int unsigned SERVE_T = (SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES;
  localparam int unsigned POINT_T = (POINT_FRAMES == 0) ? 1 : POINT_FRAMES;
  localparam int unsigned MAX_T   = (SERVE_T > POINT_T) ? SERVE_T : POINT_T;
  localparam int unsigned CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_T - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_T - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [PW:0]        NUM_P_EXT  = (PW + 1)'(NUM_PLAYERS);
  localparam logic [PW-1:0]      LAST_P     = PW'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    StStartup = 3'd0,
    StServe   = 3'd1,
    StPlay    = 3'd2,
    StPause   = 3'd3,
    StPoint   = 3'd4,
    StOver    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]  score_d [NUM_PLAYERS];
  logic [PW-1:0]       serve_q, serve_d;
  logic [PW-1:0]       winner_q, winner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_prev_q, pause_prev_q;
  logic                ball_enable_q, sq_shown_q, game_startup_q, game_over_q;

  logic                start_edge, pause_edge, point_ok;
  logic [SCORE_W-1:0]  hit_score, new_score;
  logic [PW-1:0]       next_serve;

  assign start_edge = start_btn & ~start_prev_q;
  assign pause_edge = pause_btn & ~pause_prev_q;
  assign point_ok   = point_valid && ({1'b0, point_player} < NUM_P_EXT);

  // Score of the player named by point_player, and its incremented value.
  always_comb begin
    hit_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (PW'(i) == point_player) hit_score = score_q[i];
    end
    new_score  = hit_score + SCORE_W'(1);
    next_serve = (point_player == LAST_P) ? '0 : point_player + PW'(1);
  end

  // Next-state, score, serve, winner and frame-counter logic.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    serve_d  = serve_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    case (state_q)
      StStartup: begin
        for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
        if (start_edge) begin
          state_d = StServe;
          serve_d = '0;
          cnt_d   = '0;
        end
      end
      StServe: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = StPlay;
          else                     cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StPlay: begin
        // A valid point wins over a same-cycle pause edge.
        if (point_ok) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PW'(i) == point_player) score_d[i] = new_score;
          end
          if (new_score == WIN_VAL) begin
            state_d  = StOver;
            winner_d = point_player;
          end else begin
            state_d = StPoint;
            serve_d = next_serve;
            cnt_d   = '0;
          end
        end else if (pause_edge) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_edge) state_d = StPlay;
      end
      StPoint: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            state_d = StServe;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StOver: begin
        if (start_edge) begin
          state_d = StStartup;
          for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
        end
      end
      default: state_d = StStartup;
    endcase
  end

  // State, score and bookkeeping registers; button history resets high so a
  // button held through reset release is not seen as a press.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state_q      <= StStartup;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      serve_q      <= '0;
      winner_q     <= '0;
      cnt_q        <= '0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      serve_q      <= serve_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
    end
  end

  // Moore outputs registered from the next state so they line up with state.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      ball_enable_q  <= 1'b0;
      sq_shown_q     <= 1'b0;
      game_startup_q <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      ball_enable_q  <= (state_d == StPlay);
      sq_shown_q     <= (state_d == StServe) || (state_d == StPlay) || (state_d == StPause);
      game_startup_q <= (state_d == StStartup);
      game_over_q    <= (state_d == StOver);
    end
  end

  // Pack per-player scores, player 0 in the least significant field.
  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign state        = state_q;
  assign serve_player = serve_q;
  assign winner       = winner_q;
  assign ball_enable  = ball_enable_q;
  assign sq_shown     = sq_shown_q;
  assign game_startup = game_startup_q;
  assign game_over    = game_over_q;

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of scoring players (legal 2..4).
REQ-002 SHALL have parameter SCORE_W, default 4, per-player score width in bits.
REQ-003 SHALL have parameter WIN_SCORE, default 9, winning score (legal 1..2^SCORE_W-1).
REQ-004 SHALL have parameter SERVE_FRAMES, default 60, frame ticks the ball is held before play.
REQ-005 SHALL have parameter POINT_FRAMES, default 30, frame ticks the ball is hidden after a point.
REQ-006 SHALL define PW = max(1, clog2(NUM_PLAYERS)) as the player-index width.
REQ-007 SHALL have ports, one per line:
 clk_0  input  1  pixel clock, all logic on rising edge
 rst  input  1  reset, asynchronous, active-high
 frame_tick  input  1  one-cycle pulse, once per video frame
 start_btn  input  1  debounced start level
 pause_btn  input  1  debounced pause level
 point_valid  input  1  one-cycle pulse, a point was scored
 point_player  input  PW  index of scoring player, sampled with point_valid
 state  output  3  current state encoding
 scores  output  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
 serve_player  output  PW  player the next serve goes toward
 winner  output  PW  winning player index, valid in OVER
 ball_enable  output  1  ball motion allowed
 sq_shown  output  1  ball visible
 game_startup  output  1  title screen active
 game_over  output  1  match finished

Function
REQ-008 SHALL implement states STARTUP=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5, encoded on state.
REQ-009 SHALL detect rising edges of start_btn and pause_btn with internal previous-value registers; only edges act, levels never do.
REQ-010 STARTUP: scores held 0; start edge -> SERVE, serve_player=0.
REQ-011 SERVE: count frame_tick; on the SERVE_FRAMES-th tick -> PLAY.
REQ-012 PLAY: point_valid with point_player<NUM_PLAYERS -> increment that player's score; new score == WIN_SCORE -> OVER with winner=point_player, else -> POINT with serve_player=(point_player+1) mod NUM_PLAYERS.
REQ-013 PLAY: pause edge (no valid point same cycle) -> PAUSE.
REQ-014 PAUSE: pause edge -> PLAY; frame counter, scores, serve_player frozen.
REQ-015 POINT: count frame_tick; on the POINT_FRAMES-th tick -> SERVE.
REQ-016 OVER: start edge -> STARTUP with all scores cleared to 0 on that transition.
REQ-017 Frame counter SHALL clear on every entry to SERVE or POINT and count only in those states.
REQ-018 point_valid SHALL be ignored outside PLAY and when point_player>=NUM_PLAYERS.
REQ-019 Simultaneous valid point and pause edge in PLAY: point processed, pause edge discarded.
REQ-020 Simultaneous start and pause edges: only the edge meaningful in the current state acts.
REQ-021 Scores SHALL never exceed WIN_SCORE (match ends at equality); no wrap.
REQ-022 Outputs SHALL be registered, Moore-decoded: ball_enable=1 only in PLAY; sq_shown=1 in SERVE, PLAY, PAUSE; game_startup=1 only in STARTUP; game_over=1 only in OVER.
REQ-023 State and score updates SHALL appear one clk_0 cycle after the causing input is sampled.
REQ-024 SERVE_FRAMES or POINT_FRAMES of 0 SHALL behave as 1.

Reset
REQ-025 rst high SHALL immediately force state=STARTUP, scores=0, serve_player=0, winner=0, frame counter=0, ball_enable=0, sq_shown=0, game_startup=1, game_over=0.
REQ-026 Edge-detect previous-value registers SHALL reset to 1, so a button held through reset release produces no edge.
REQ-027 rst asserted mid-match (any state) SHALL abandon the match with no further score change.

Verification
REQ-028 Reset then start pulse -> state 1; after 60 frame_ticks -> state 2, ball_enable=1 next cycle.
REQ-029 In PLAY, point_valid with point_player=1 -> scores[7:4]=1, state 4, serve_player=0; after 30 ticks -> state 1.
REQ-030 Player 0 scores nine times (defaults) -> state 5, winner=0, game_over=1, scores[3:0]=9; start edge -> state 0, scores=0.
REQ-031 Pause edge in PLAY -> state 3, ball_enable=0, frame_ticks and point_valid ignored; second pause edge -> state 2, scores unchanged.
REQ-032 Same-cycle point_valid (player 0) and pause edge in PLAY -> state 4, scores[3:0] incremented, no PAUSE.
REQ-033 NUM_PLAYERS=3, point_player=3 in PLAY -> ignored; point by player 2 -> serve_player=0; rst during SERVE -> STARTUP, scores=0.
